// File: rtl/jtag_master.sv
// JTAG initiator: walks an on-board TAP from Run-Test/Idle through IR/DR scans or a reset.
// Optional feature macro JTAG_MASTER_RUNTEST_EN adds rti_cycles of Run-Test/Idle clocking before done.
module jtag_master #(
  parameter int MAX_LEN = 32,
  parameter int LEN_W   = 6,
  parameter int CLK_DIV = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               cmd_ir,
  input  logic               cmd_reset,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
`ifdef JTAG_MASTER_RUNTEST_EN
  input  logic [15:0]        rti_cycles,
`endif
  output logic               ready,
  output logic               done,
  output logic [MAX_LEN-1:0] tdo_data,
  output logic               TCK,
  output logic               TMS,
  output logic               TDI,
  input  logic               TDO
);
  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IDX_W  = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int STEP_W = (LEN_W > 16) ? LEN_W : 16;

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_WALK_IN, S_SHIFT, S_WALK_OUT, S_RTI, S_DONE
  } state_t;

  state_t              state;
  logic [DIV_W-1:0]    div_cnt;
  logic [STEP_W-1:0]   step, nstep;
  logic [LEN_W-1:0]    len_q, len_c;
  logic [MAX_LEN-1:0]  data_q;
  logic                ir_q, reset_q;
`ifdef JTAG_MASTER_RUNTEST_EN
  logic [15:0]         rti_q;
`endif
  logic                div_last, seg_last, nxt_tms, nxt_tdi;

  assign len_c    = (cmd_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cmd_len;
  assign div_last = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign nstep    = step + STEP_W'(1);

  // Each segment is a run of TCK cycles; seg_last marks the final one, nxt_* is the following bit.
  always_comb begin
    seg_last = 1'b0;
    nxt_tms  = 1'b0;
    nxt_tdi  = 1'b0;
    case (state)
      S_INIT: begin
        seg_last = (step == STEP_W'(5));
        nxt_tms  = (nstep < STEP_W'(5));
      end
      S_WALK_IN: begin
        seg_last = (step == (reset_q ? STEP_W'(5) : ir_q ? STEP_W'(3) : STEP_W'(2)));
        nxt_tms  = (nstep < (reset_q ? STEP_W'(5) : ir_q ? STEP_W'(2) : STEP_W'(1)));
      end
      S_SHIFT: begin
        seg_last = (step == STEP_W'(len_q) - STEP_W'(1));
        nxt_tms  = (nstep == STEP_W'(len_q) - STEP_W'(1));
        nxt_tdi  = data_q[nstep[IDX_W-1:0]];
      end
      S_WALK_OUT: seg_last = (step == STEP_W'(1));
`ifdef JTAG_MASTER_RUNTEST_EN
      S_RTI: seg_last = (step == STEP_W'(rti_q) - STEP_W'(1));
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_INIT;
      step     <= '0;
      div_cnt  <= '0;
      TCK      <= 1'b0;
      TMS      <= 1'b1;
      TDI      <= 1'b0;
      ready    <= 1'b0;
      done     <= 1'b0;
      tdo_data <= '0;
      len_q    <= '0;
      data_q   <= '0;
      ir_q     <= 1'b0;
      reset_q  <= 1'b0;
`ifdef JTAG_MASTER_RUNTEST_EN
      rti_q    <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: if (start) begin
          ready   <= 1'b0;
          len_q   <= len_c;
          data_q  <= cmd_data;
          ir_q    <= cmd_ir;
          reset_q <= cmd_reset;
`ifdef JTAG_MASTER_RUNTEST_EN
          rti_q   <= rti_cycles;
`endif
          step    <= '0;
          div_cnt <= '0;
          TDI     <= 1'b0;
          for (int k = 0; k < MAX_LEN; k++)
            if (k >= int'(len_c)) tdo_data[k] <= 1'b0;
          // A zero-length scan never leaves Run-Test/Idle
          if (cmd_reset || len_c != '0) begin
            state <= S_WALK_IN;
            TMS   <= 1'b1;
          end else begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          if (!done) begin
            done <= 1'b1;
          end else begin
            done  <= 1'b0;
            ready <= 1'b1;
            state <= S_IDLE;
          end
        end
        default: begin
          if (!div_last) begin
            div_cnt <= div_cnt + 1'b1;
          end else begin
            div_cnt <= '0;
            if (!TCK) begin
              TCK <= 1'b1;
              if (state == S_SHIFT) tdo_data[step[IDX_W-1:0]] <= TDO;
            end else begin
              TCK <= 1'b0;
              if (!seg_last) begin
                step <= nstep;
                TMS  <= nxt_tms;
                TDI  <= nxt_tdi;
              end else begin
                step <= '0;
                case (state)
                  S_INIT: begin
                    state <= S_IDLE;
                    ready <= 1'b1;
                  end
                  S_WALK_IN: begin
                    if (reset_q) begin
                      state <= S_DONE;
                      done  <= 1'b1;
                    end else begin
                      state <= S_SHIFT;
                      TMS   <= (len_q == LEN_W'(1));
                      TDI   <= data_q[0];
                    end
                  end
                  S_SHIFT: begin
                    state <= S_WALK_OUT;
                    TMS   <= 1'b1;
                    TDI   <= 1'b0;
                  end
                  S_WALK_OUT: begin
                    TMS <= 1'b0;
`ifdef JTAG_MASTER_RUNTEST_EN
                    if (rti_q != '0) begin
                      state <= S_RTI;
                    end else
`endif
                    begin
                      state <= S_DONE;
                      done  <= 1'b1;
                    end
                  end
                  default: begin
                    state <= S_DONE;
                    done  <= 1'b1;
                  end
                endcase
              end
            end
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_jtag_master.sv
// Bench for jtag_master: directed and random scans against a behavioural TAP and a TMS-rule model.
module tb_jtag_master;
  localparam int MAX_LEN = 32;
  localparam int LEN_W   = 6;
  localparam int CLK_DIV = 2;
  localparam logic [31:0] IDCODE_VAL = 32'h1BA5_E0F3;
  localparam logic [3:0]  OP_IDCODE  = 4'h7;
  localparam logic [3:0]  OP_BYPASS  = 4'hF;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, cmd_ir = 1'b0, cmd_reset = 1'b0;
  logic [LEN_W-1:0]   cmd_len = '0;
  logic [MAX_LEN-1:0] cmd_data = '0;
`ifdef JTAG_MASTER_RUNTEST_EN
  logic [15:0]        rti_cycles = '0;
`endif
  logic ready, done, TCK, TMS, TDI, TDO;
  logic [MAX_LEN-1:0] tdo_data;
  int vectors = 0, miscompares = 0;

  always #5 clk = ~clk;

  jtag_master #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .rst(rst), .start(start), .cmd_ir(cmd_ir), .cmd_reset(cmd_reset),
    .cmd_len(cmd_len), .cmd_data(cmd_data),
`ifdef JTAG_MASTER_RUNTEST_EN
    .rti_cycles(rti_cycles),
`endif
    .ready(ready), .done(done), .tdo_data(tdo_data),
    .TCK(TCK), .TMS(TMS), .TDI(TDI), .TDO(TDO)
  );

  // Behavioural target TAP: IDCODE (32 bit) and BYPASS data registers, 4-bit IR.
  typedef enum logic [3:0] {
    TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PA_DR, EX2_DR, UPD_DR,
    SEL_IR, CAP_IR, SH_IR, EX1_IR, PA_IR, EX2_IR, UPD_IR
  } tap_t;
  tap_t tap = TLR;
  logic [3:0]  ir = OP_IDCODE, ir_sr = '0;
  logic [31:0] dr_sr = '0;
  logic byp = 1'b0, tap_tdo = 1'b0, loop = 1'b0;

  function automatic tap_t tap_next(input tap_t s, input logic m);
    case (s)
      TLR:    return m ? TLR    : RTI;
      RTI:    return m ? SEL_DR : RTI;
      SEL_DR: return m ? SEL_IR : CAP_DR;
      CAP_DR: return m ? EX1_DR : SH_DR;
      SH_DR:  return m ? EX1_DR : SH_DR;
      EX1_DR: return m ? UPD_DR : PA_DR;
      PA_DR:  return m ? EX2_DR : PA_DR;
      EX2_DR: return m ? UPD_DR : SH_DR;
      UPD_DR: return m ? SEL_DR : RTI;
      SEL_IR: return m ? TLR    : CAP_IR;
      CAP_IR: return m ? EX1_IR : SH_IR;
      SH_IR:  return m ? EX1_IR : SH_IR;
      EX1_IR: return m ? UPD_IR : PA_IR;
      PA_IR:  return m ? EX2_IR : PA_IR;
      EX2_IR: return m ? UPD_IR : SH_IR;
      default: return m ? SEL_DR : RTI;
    endcase
  endfunction

  always @(posedge TCK) begin
    case (tap)
      TLR:    ir <= OP_IDCODE;
      CAP_DR: if (ir == OP_IDCODE) dr_sr <= IDCODE_VAL; else byp <= 1'b0;
      SH_DR:  if (ir == OP_IDCODE) dr_sr <= {TDI, dr_sr[31:1]}; else byp <= TDI;
      CAP_IR: ir_sr <= 4'b0001;
      SH_IR:  ir_sr <= {TDI, ir_sr[3:1]};
      UPD_IR: ir <= ir_sr;
      default: ;
    endcase
    tap <= tap_next(tap, TMS);
  end

  always @(negedge TCK)
    tap_tdo <= (tap == SH_DR) ? ((ir == OP_IDCODE) ? dr_sr[0] : byp) :
               (tap == SH_IR) ? ir_sr[0] : 1'b0;

  assign TDO = loop ? TDI : tap_tdo;

  // Record TMS/TDI at every TCK rise, and done at every clk low phase
  logic rec = 1'b0;
  bit   tms_q[$], tdi_q[$];
  int   done_cnt = 0;
  always @(posedge TCK) if (rec) begin tms_q.push_back(TMS); tdi_q.push_back(TDI); end
  always @(negedge clk) if (rec && done) done_cnt = done_cnt + 1;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] q_slice(input bit q[$], input int off, input int n);
    logic [127:0] v;
    v = '0;
    for (int k = 0; k < n; k++) if (off + k < q.size()) v[k] = q[off + k];
    return v;
  endfunction

  function automatic logic [31:0] mask(input int n);
    return (n >= 32) ? 32'hFFFF_FFFF : ((32'h1 << n) - 32'h1);
  endfunction

  // Expected TMS stream (bit i = i-th TCK rise), TCK count and clamped length.
  task automatic model_cmd(input bit ir_c, input bit rs, input int len, input int rti,
                           output logic [127:0] tv, output int cnt, output int n);
    tv = '0; cnt = 0;
    n = (len > MAX_LEN) ? MAX_LEN : len;
    if (rs) begin
      for (int i = 0; i < 5; i++) tv[i] = 1'b1;
      cnt = 6;
    end else if (n > 0) begin
      tv[0] = 1'b1; cnt = 1;
      if (ir_c) begin tv[1] = 1'b1; cnt = 2; end
      cnt = cnt + 2;
      for (int k = 0; k < n; k++) begin tv[cnt] = (k == n - 1); cnt++; end
      tv[cnt] = 1'b1;
      cnt = cnt + 2 + rti;
    end
  endtask

  // Issues one command; lat counts clk edges from the one sampling start to the one raising done.
  task automatic run_cmd(input bit ir_c, input bit rs, input int len, input logic [31:0] data,
                         input int rti, input int poke_at, output int lat);
    @(negedge clk);
    cmd_ir = ir_c; cmd_reset = rs; cmd_len = LEN_W'(len); cmd_data = data; start = 1'b1;
`ifdef JTAG_MASTER_RUNTEST_EN
    rti_cycles = 16'(rti);
`endif
    tms_q.delete(); tdi_q.delete(); done_cnt = 0; rec = 1'b1;
    @(posedge clk); lat = 1;
    @(negedge clk); start = 1'b0;
    while (!done && lat < 4000) begin
      if (lat == poke_at) begin start = 1'b1; cmd_data = ~data; cmd_ir = ~ir_c; end
      else start = 1'b0;
      @(posedge clk); lat++;
      @(negedge clk);
    end
    start = 1'b0;
    repeat (4) @(negedge clk);
    rec = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [127:0] tv;
    logic [31:0]  d;
    int cnt, n, lat, cyc, len, rti;
    rti = 0;

    repeat (3) @(negedge clk);
    chk("rst_tck", TCK, 0);
    chk("rst_tms", TMS, 1);
    chk("rst_tdi", TDI, 0);
    chk("rst_ready", ready, 0);
    chk("rst_done", done, 0);
    chk("rst_tdo_data", tdo_data, 0);

    tms_q.delete(); done_cnt = 0; rec = 1'b1;
    rst = 1'b0;
    cyc = 0;
    while (!ready && cyc < 1000) begin @(posedge clk); cyc++; @(negedge clk); end
    rec = 1'b0;
    chk("init_cycles", cyc, 6 * 2 * CLK_DIV);
    chk("init_tcks", tms_q.size(), 6);
    chk("init_tms", q_slice(tms_q, 0, 6), 6'b011111);
    chk("init_done", done_cnt, 0);
    chk("idle_tck", TCK, 0);
    chk("idle_tms", TMS, 0);

    // DR scan 8 bits, TDO looped back to TDI
    loop = 1'b1;
    run_cmd(0, 0, 8, 32'hA5, 0, 0, lat);
    model_cmd(0, 0, 8, 0, tv, cnt, n);
    chk("dr8_tcks", tms_q.size(), 13);
    chk("dr8_tms", q_slice(tms_q, 0, cnt), tv);
    chk("dr8_tdi", q_slice(tdi_q, 3, n), 32'hA5);
    chk("dr8_tdo_data", tdo_data, 32'h0000_00A5);
    chk("dr8_latency", lat, cnt * 2 * CLK_DIV + 1);
    chk("dr8_done_pulses", done_cnt, 1);
    chk("dr8_ready", ready, 1);

    // IR scan selecting IDCODE, then a 32-bit DR read
    loop = 1'b0;
    run_cmd(1, 0, 4, {28'h0, OP_IDCODE}, 0, 0, lat);
    model_cmd(1, 0, 4, 0, tv, cnt, n);
    chk("ir_tcks", tms_q.size(), 10);
    chk("ir_tms", q_slice(tms_q, 0, cnt), tv);
    chk("ir_capture", tdo_data, 32'h1);
    chk("ir_tap_ir", ir, OP_IDCODE);
    chk("ir_tap_state", tap, RTI);
    run_cmd(0, 0, 32, 32'h0, 0, 0, lat);
    chk("idcode_tcks", tms_q.size(), 37);
    chk("idcode_value", tdo_data, IDCODE_VAL);

    // Zero-length scan
    run_cmd(0, 0, 0, 32'hFFFF_FFFF, 0, 0, lat);
    chk("len0_tcks", tms_q.size(), 0);
    chk("len0_latency", lat, 2);
    chk("len0_tdo_data", tdo_data, 0);
    chk("len0_done_pulses", done_cnt, 1);

    // BYPASS and random DR scans through it
    run_cmd(1, 0, 4, {28'h0, OP_BYPASS}, 0, 0, lat);
    chk("byp_tap_ir", ir, OP_BYPASS);
    for (int i = 0; i < 5; i++) begin
      len = int'($urandom_range(1, MAX_LEN));
      d   = $urandom;
      run_cmd(0, 0, len, d, 0, 0, lat);
      model_cmd(0, 0, len, 0, tv, cnt, n);
      chk("byp_tms", q_slice(tms_q, 0, cnt), tv);
      chk("byp_tcks", tms_q.size(), cnt);
      chk("byp_tdo_data", tdo_data, (d << 1) & mask(n));
      chk("byp_latency", lat, cnt * 2 * CLK_DIV + 1);
    end

    // Reset command with cmd_ir also set: TAP back to IDCODE
    run_cmd(1, 1, 8, 32'h3C, 0, 0, lat);
    model_cmd(1, 1, 8, 0, tv, cnt, n);
    chk("rstcmd_tcks", tms_q.size(), 6);
    chk("rstcmd_tms", q_slice(tms_q, 0, cnt), tv);
    chk("rstcmd_latency", lat, 6 * 2 * CLK_DIV + 1);
    chk("rstcmd_tap_ir", ir, OP_IDCODE);
    chk("rstcmd_tap_state", tap, RTI);

    // Random loopback scans, lengths beyond MAX_LEN clamp
    loop = 1'b1;
    for (int i = 0; i < 6; i++) begin
      len = (i == 0) ? 40 : int'($urandom_range(1, 40));
      d   = $urandom;
      run_cmd($urandom_range(0, 1) == 1, 0, len, d, 0, 0, lat);
      chk("loop_tdo_data", tdo_data, d & mask((len > MAX_LEN) ? MAX_LEN : len));
      chk("loop_done_pulses", done_cnt, 1);
    end

    // start re-pulsed mid-scan with other data is ignored
    run_cmd(0, 0, 16, 32'h1234_5678, 0, 20, lat);
    model_cmd(0, 0, 16, 0, tv, cnt, n);
    chk("poke_tdo_data", tdo_data, 32'h0000_5678);
    chk("poke_tcks", tms_q.size(), cnt);
    chk("poke_done_pulses", done_cnt, 1);
    chk("poke_latency", lat, cnt * 2 * CLK_DIV + 1);

    // rst in the middle of SHIFT
    @(negedge clk);
    cmd_ir = 1'b0; cmd_reset = 1'b0; cmd_len = LEN_W'(8); cmd_data = 32'hFF; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (4 * 2 * CLK_DIV) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_tck", TCK, 0);
    chk("midrst_tms", TMS, 1);
    chk("midrst_ready", ready, 0);
    chk("midrst_tdo_data", tdo_data, 0);
    rst = 1'b0;
    cyc = 0;
    while (!ready && cyc < 1000) begin @(posedge clk); cyc++; @(negedge clk); end
    chk("midrst_init_cycles", cyc, 6 * 2 * CLK_DIV);
    loop = 1'b0;
    run_cmd(0, 0, 32, 32'h0, 0, 0, lat);
    chk("midrst_idcode", tdo_data, IDCODE_VAL);

`ifdef JTAG_MASTER_RUNTEST_EN
    loop = 1'b1;
    rti  = 10;
    run_cmd(0, 0, 4, 32'h9, rti, 0, lat);
    model_cmd(0, 0, 4, rti, tv, cnt, n);
    chk("rti_tcks", tms_q.size(), 19);
    chk("rti_tms", q_slice(tms_q, 0, cnt), tv);
    chk("rti_latency", lat, cnt * 2 * CLK_DIV + 1);
    chk("rti_tdo_data", tdo_data, 32'h9);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/jtag_master.md
Name: jtag_master

Overview:
- Host-side JTAG initiator: generates TCK/TMS/TDI from the system clock and captures TDO, driving an on-board TAP (IDCODE/BYPASS/SAMPLE/EXTEST/INTEST/USERCODE/RUNBIST) without an external probe.
- Accepts one IR-scan, DR-scan or reset command at a time.
- Walks the TAP from Run-Test/Idle to Shift-IR or Shift-DR, shifts N bits LSB-first, and returns to Run-Test/Idle.
- Intended as a BIST/self-test stimulus source, with its TCK/TMS/TDI/TDO lines routable to the LA header.

Parameters:
- MAX_LEN, 32: maximum scan length in bits; width of cmd_data and tdo_data.
- LEN_W, 6: width of cmd_len; must satisfy 2^LEN_W > MAX_LEN.
- CLK_DIV, 4: clk cycles per TCK half-period; legal range is 1 and up.

Ports:
- clk  input  1  system clock; all logic is on its rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-clk command strobe; sampled only when ready=1.
- cmd_ir  input  1  1 = IR scan, 0 = DR scan.
- cmd_reset  input  1  with start: go to Test-Logic-Reset and then Run-Test/Idle; overrides cmd_ir.
- cmd_len  input  LEN_W  number of bits to shift, 0..MAX_LEN.
- cmd_data  input  MAX_LEN  TDI payload; bit0 is shifted first.
- ready  output  1  idle and able to accept a command.
- done  output  1  one-clk pulse when a command completes.
- tdo_data  output  MAX_LEN  captured TDO bits; bit0 is the first bit captured.
- TCK  output  1  JTAG clock.
- TMS  output  1  JTAG mode select.
- TDI  output  1  JTAG data to the target.
- TDO  input  1  JTAG data from the target.

Behaviour:
- Reset values: TCK=0, TMS=1, TDI=0, ready=0, done=0, tdo_data=0, all counters 0.
- Init after reset: the master sends 5 TCK cycles with TMS=1, then 1 with TMS=0, reaching Run-Test/Idle. When init ends, ready=1; done is not pulsed.
- TCK timing:
  - Each TCK cycle is 2*CLK_DIV clk cycles: a low half followed by a high half.
  - TMS and TDI update only at the start of the low half.
  - TDO is sampled on the clk where TCK rises.
  - Between commands TCK stays low and TMS=0.
- State machine (INIT, IDLE, WALK_IN, SHIFT, WALK_OUT, DONE):
  - INIT: the reset sequence above. Goes to IDLE.
  - IDLE: ready=1. start latches cmd_* and sets ready=0 on the next clk.
  - WALK_IN TMS sequence: DR = 1,0,0 (Select-DR, Capture-DR, Shift-DR). IR = 1,1,0,0. Reset command = 1,1,1,1,1,0, then go to DONE.
  - SHIFT: bit k drives TDI=cmd_data[k]. TMS=0 for k<N-1 and TMS=1 on k=N-1 (Exit1). TDO sampled at that TCK rise goes into tdo_data[k].
  - WALK_OUT TMS sequence: 1 (Update), 0 (Run-Test/Idle).
  - DONE: after the final TCK falling edge, done=1 for one clk, then IDLE with ready=1.
- tdo_data:
  - Bits k>=N are cleared to 0 when a command is accepted.
  - tdo_data holds its value until the next accepted command.
- Total TCK cycles per command: DR = N+5, IR = N+6, reset = 6.
- cmd_len=0: no TCK is generated; done pulses 2 clks after start; tdo_data=0.
- cmd_len>MAX_LEN: clamped to MAX_LEN.
- start while ready=0: ignored, with no queueing.
- cmd_reset and cmd_ir both set: the reset command is executed.
- rst mid-command: outputs return to reset values immediately and INIT restarts. Any partial scan is abandoned, and the TAP is resynchronised by INIT.

Optional Feature:
- Macro: JTAG_MASTER_RUNTEST_EN.
- When defined:
  - Adds input rti_cycles [15:0], latched with start.
  - After WALK_OUT the master stays in Run-Test/Idle for rti_cycles extra TCK cycles with TMS=0, before DONE. This provides clock to RUNBIST.
  - rti_cycles=0 behaves exactly like the macro-undefined build.
- When undefined: no port, and no extra cycles.

Test Plan:
- Reset with CLK_DIV=2 -> TCK period 4 clk; TMS=1 for 5 TCKs then 0; ready rises after 24 clk; done stays 0.
- DR scan, len=8, cmd_data=8'hA5, TDO looped to TDI -> TMS sequence 1,0,0,0×7,1,1,0; 13 TCKs; tdo_data=32'h000000A5; one done pulse.
- IR scan, len=4, data=4'h7, against a TAP model -> 10 TCKs; the TAP latches IDCODE. A following DR scan with len=32 returns that model's ID value in tdo_data.
- cmd_len=0 -> no TCK edges; done exactly 2 clks after start; tdo_data=0.
- start pulsed again mid-scan with different data -> ignored; the first scan result is unchanged. rst asserted mid-SHIFT -> TCK=0 and TMS=1 on the next clk, and INIT repeats.
- JTAG_MASTER_RUNTEST_EN defined, rti_cycles=10, DR len=4 -> 19 TCKs total, with the last 11 at TMS=0; done follows the last TCK fall.
